// File: rtl/draw_sequence_datapath.sv
// draw_sequence_datapath
//   Walks elementSeq (filled by the sort-sequence stage) and renders each element
//   as a vertical bar to the VGA plotter, one pixel per plot cycle. Bar i starts at
//   x = X0 + i*block_width, height (elementSeq[i]+1)*HEIGHT_STEP, bottom row BASE_Y-1.
//   Pixels are issued column-major, bottom-up.
//
//   Optional feature: define CLEAR_SCREEN_EN to black-fill the drawing area
//   (row-major, one pixel per cycle) before the first bar is drawn.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   go_draw           start request, sampled in IDLE only
//   numElements       number of bars (0..31), latched at start
//   block_width       bar pitch in pixels, latched at start (0 treated as 1)
//   elementSeq_addr   elementSeq read address
//   elementSeq_out    elementSeq read data, valid 2 cycles after address change
//   x, y, colour      pixel coordinates and colour
//   plot              pixel write strobe
//   busy              high whenever not idle
//   draw_done         one-cycle pulse after the last pixel has been issued
module draw_sequence_datapath #(
  parameter logic [9:0] X0          = 10'd20,
  parameter logic [8:0] BASE_Y      = 9'd400,
  parameter logic [8:0] HEIGHT_STEP = 9'd8,
  parameter logic [2:0] BAR_COLOUR  = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_draw,
  input  logic [4:0] numElements,
  input  logic [9:0] block_width,
  output logic [4:0] elementSeq_addr,
  input  logic [4:0] elementSeq_out,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       draw_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t     state;
  logic [4:0] num_r;
  logic [9:0] bw_r;       // effective pitch (never 0)
  logic [9:0] last_col;   // last drawn column inside a bar
  logic [4:0] idx;
  logic [9:0] bar_x;      // X0 + idx*bw_r, accumulated instead of multiplied
  logic [8:0] h;
  logic [9:0] col;
  logic [8:0] row;
  logic       wait_cnt;

  logic [9:0] bw_eff_in;
  logic [9:0] last_col_in;

  always_comb begin
    bw_eff_in   = (block_width == '0) ? 10'd1 : block_width;
    // one-pixel gap on the right; widths 0..2 all leave a single column
    last_col_in = (block_width <= 10'd2) ? '0 : block_width - 10'd2;
  end

`ifdef CLEAR_SCREEN_EN
  logic [14:0] clr_w;
  logic [14:0] clr_cx;
  logic [7:0]  clr_cy;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      num_r           <= '0;
      bw_r            <= 10'd1;
      last_col        <= '0;
      idx             <= '0;
      bar_x           <= '0;
      h               <= '0;
      col             <= '0;
      row             <= '0;
      wait_cnt        <= 1'b0;
      elementSeq_addr <= '0;
      x               <= '0;
      y               <= '0;
      colour          <= '0;
      plot            <= 1'b0;
      busy            <= 1'b0;
      draw_done       <= 1'b0;
`ifdef CLEAR_SCREEN_EN
      clr_w           <= '0;
      clr_cx          <= '0;
      clr_cy          <= '0;
`endif
    end else begin
      plot      <= 1'b0;
      draw_done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (go_draw) begin
            busy            <= 1'b1;
            num_r           <= numElements;
            bw_r            <= bw_eff_in;
            last_col        <= last_col_in;
            idx             <= '0;
            elementSeq_addr <= '0;
            bar_x           <= X0;
            if (numElements == '0) begin
              state <= S_DONE;
            end else begin
`ifdef CLEAR_SCREEN_EN
              clr_w  <= {10'd0, numElements} * {5'd0, bw_eff_in};
              clr_cx <= '0;
              clr_cy <= '0;
              x      <= X0;
              y      <= BASE_Y - 9'd256;
              colour <= '0;
              plot   <= 1'b1;
              state  <= S_CLEAR;
`else
              state  <= S_FETCH;
`endif
            end
          end
        end
`ifdef CLEAR_SCREEN_EN
        S_CLEAR: begin
          if (clr_cx == clr_w - 15'd1) begin
            if (clr_cy == 8'd255) begin
              state <= S_FETCH;
            end else begin
              clr_cx <= '0;
              clr_cy <= clr_cy + 8'd1;
              x      <= X0;
              y      <= y + 9'd1;
              plot   <= 1'b1;
            end
          end else begin
            clr_cx <= clr_cx + 15'd1;
            x      <= x + 10'd1;
            plot   <= 1'b1;
          end
        end
`endif
        S_FETCH: begin
          // address already presented on entry; give the RAM its two cycles
          wait_cnt <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt) begin
            h      <= ({4'd0, elementSeq_out} + 9'd1) * HEIGHT_STEP;
            col    <= '0;
            row    <= '0;
            x      <= bar_x;
            y      <= BASE_Y - 9'd1;
            colour <= BAR_COLOUR;
            plot   <= 1'b1;
            state  <= S_DRAW;
          end else begin
            wait_cnt <= 1'b1;
          end
        end
        S_DRAW: begin
          // x/y already hold the pixel being plotted; decide the next one
          if (row == h - 9'd1) begin
            if (col == last_col) begin
              state <= S_NEXT;
            end else begin
              col  <= col + 10'd1;
              row  <= '0;
              x    <= x + 10'd1;
              y    <= BASE_Y - 9'd1;
              plot <= 1'b1;
            end
          end else begin
            row  <= row + 9'd1;
            y    <= y - 9'd1;
            plot <= 1'b1;
          end
        end
        S_NEXT: begin
          if (idx == num_r - 5'd1) begin
            state <= S_DONE;
          end else begin
            idx             <= idx + 5'd1;
            elementSeq_addr <= idx + 5'd1;
            bar_x           <= bar_x + bw_r;
            state           <= S_FETCH;
          end
        end
        S_DONE: begin
          draw_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sequence_datapath.sv
module tb_draw_sequence_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       go_draw;
  logic [4:0] numElements;
  logic [9:0] block_width;
  logic [4:0] elementSeq_addr;
  logic [4:0] elementSeq_out;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       draw_done;

  draw_sequence_datapath dut (
    .clk             (clk),
    .reset           (reset),
    .go_draw         (go_draw),
    .numElements     (numElements),
    .block_width     (block_width),
    .elementSeq_addr (elementSeq_addr),
    .elementSeq_out  (elementSeq_out),
    .x               (x),
    .y               (y),
    .colour          (colour),
    .plot            (plot),
    .busy            (busy),
    .draw_done       (draw_done)
  );

  always #5 clk = ~clk;

  // elementSeq RAM with two-cycle read latency
  logic [4:0] mem [32];
  logic [4:0] ram_r1;
  always @(posedge clk) begin
    ram_r1         <= mem[elementSeq_addr];
    elementSeq_out <= ram_r1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int last_plot_cyc = 0;
  int done_cyc = 0;
  logic [21:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard consumer: every plotted pixel must match the next expected one
  always @(negedge clk) begin
    logic [21:0] e;
    if (draw_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (plot) begin
      plot_cnt++;
      last_plot_cyc = cyc;
      if (exp_q.size() == 0) check_val("extra_plot", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check_val("pixel", {10'd0, x, y, colour}, {10'd0, e});
      end
    end
  end

  function automatic int clr_px(input int num, input int bw);
    int bwe = (bw == 0) ? 1 : bw;
`ifdef CLEAR_SCREEN_EN
    return num * bwe * 256;
`else
    return 0 * num * bwe;
`endif
  endfunction

  task automatic push_draw(input int num, input int bw);
    int bwe = (bw == 0) ? 1 : bw;
    int ncol = (bwe <= 1) ? 1 : bwe - 1;
    logic [9:0] px;
    logic [8:0] py;
`ifdef CLEAR_SCREEN_EN
    if (num > 0)
      for (int r = 0; r < 256; r++)
        for (int c = 0; c < num * bwe; c++) begin
          px = 10'(20 + c);
          py = 9'(144 + r);
          exp_q.push_back({px, py, 3'b000});
        end
`endif
    for (int i = 0; i < num; i++) begin
      int hh = (int'(mem[i]) + 1) * 8;
      for (int c = 0; c < ncol; c++)
        for (int r = 0; r < hh; r++) begin
          px = 10'(20 + i * bwe + c);
          py = 9'(399 - r);
          exp_q.push_back({px, py, 3'b111});
        end
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk); #1;
      if (draw_done) seen = 1;
    end
    check_val({tag, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_draw(input string tag, input int num, input int bw,
                          input int exp_plots, input int pulse_at);
    int p0, d0;
    bit seen = 0;
    numElements = 5'(num);
    block_width = 10'(bw);
    push_draw(num, bw);
    p0 = plot_cnt;
    d0 = done_cnt;
    @(negedge clk); go_draw = 1'b1;
    @(negedge clk); go_draw = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk); #1;
      go_draw = (c == pulse_at);
      if (draw_done) seen = 1;
    end
    go_draw = 1'b0;
    check_val({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    repeat (6) @(negedge clk);
    #1;
    check_val({tag, "_plots"}, plot_cnt - p0, exp_plots + clr_px(num, bw));
    check_val({tag, "_done_cnt"}, done_cnt - d0, 32'd1);
    check_val({tag, "_drained"}, exp_q.size(), 32'd0);
    check_val({tag, "_done_after_last"}, {31'd0, done_cyc > last_plot_cyc}, 32'd1);
    exp_q.delete();
  endtask

  initial begin
    int p0, d0;
    bit hit;
    reset = 1'b1;
    go_draw = 1'b0;
    numElements = '0;
    block_width = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_val("rst_plot", {31'd0, plot}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, draw_done}, 32'd0);
    check_val("rst_addr", {27'd0, elementSeq_addr}, 32'd0);
    check_val("rst_xyc", {10'd0, x, y, colour}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // main three-bar case: heights 24, 8, 16 with three columns each
    mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
    run_draw("main", 3, 4, 144, -1);

    // empty draw: no pixels, pulse on the second edge after go is sampled
    p0 = plot_cnt;
    @(negedge clk); numElements = 5'd0; block_width = 10'd4; go_draw = 1'b1;
    @(posedge clk); #1; go_draw = 1'b0;
    check_val("zero_done_e0", {31'd0, draw_done}, 32'd0);
    check_val("zero_busy_e0", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check_val("zero_done_e1", {31'd0, draw_done}, 32'd1);
    check_val("zero_busy_e1", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_val("zero_done_e2", {31'd0, draw_done}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("zero_plots", plot_cnt - p0, 32'd0);

    // tallest bar at width 1, then a minimum bar
    mem[0] = 5'd31; mem[1] = 5'd0;
    run_draw("w1", 2, 1, 264, -1);

    // width 0 behaves as width 1
    mem[0] = 5'd0; mem[1] = 5'd1;
    run_draw("w0", 2, 0, 24, -1);

    // go pulsed mid-draw is ignored
    mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
    run_draw("midgo", 3, 4, 144, 30);

    // go held high: two identical back-to-back draws
    d0 = done_cnt;
    numElements = 5'd3; block_width = 10'd4;
    push_draw(3, 4);
    push_draw(3, 4);
    @(negedge clk); go_draw = 1'b1;
    wait_done("hold1", 20000);
    check_val("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    check_val("hold_restart_busy", {31'd0, busy}, 32'd1);
    go_draw = 1'b0;
    wait_done("hold2", 20000);
    repeat (4) @(negedge clk);
    check_val("hold_done_cnt", done_cnt - d0, 32'd2);
    check_val("hold_drained", exp_q.size(), 32'd0);
    exp_q.delete();

    // reset while drawing bar 2
    push_draw(3, 4);
    p0 = plot_cnt;
    @(negedge clk); go_draw = 1'b1;
    @(negedge clk); go_draw = 1'b0;
    hit = 0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk); #1;
      if (plot_cnt - p0 >= clr_px(3, 4) + 101) hit = 1;
    end
    check_val("rstmid_reach", {31'd0, hit}, 32'd1);
    check_val("rstmid_bar2", {27'd0, elementSeq_addr}, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("rstmid_plot", {31'd0, plot}, 32'd0);
    check_val("rstmid_busy", {31'd0, busy}, 32'd0);
    check_val("rstmid_addr", {27'd0, elementSeq_addr}, 32'd0);
    check_val("rstmid_done", {31'd0, draw_done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    p0 = plot_cnt;
    repeat (40) @(negedge clk);
    #1;
    check_val("rstmid_no_done", done_cnt - d0, 32'd0);
    check_val("rstmid_no_plot", plot_cnt - p0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
